// File: rtl/apb_regfile_slave.sv
// APB3 slave register file: NREGS-1 RW registers plus a read-only status word at NREGS-1.
// Define APB_REGFILE_WAIT_EN to honour the WAIT parameter; otherwise every transfer is zero-wait.
module apb_regfile_slave #(
   parameter int AWIDTH    = 4,
   parameter int DWIDTH    = 8,
   parameter int NREGS     = 8,
   parameter int WAIT      = 2,
   parameter int RESET_VAL = 0
) (
   input  logic                        PCLK,
   input  logic                        PRESET,
   input  logic                        PSEL,
   input  logic                        PENABLE,
   input  logic                        PWRITE,
   input  logic [AWIDTH-1:0]           PADDR,
   input  logic [DWIDTH-1:0]           PWDATA,
   output logic [DWIDTH-1:0]           PRDATA,
   output logic                        PREADY,
   output logic                        PSLVERR,
   input  logic [DWIDTH-1:0]           status_i,
   output logic [(NREGS-1)*DWIDTH-1:0] regs_o,
   output logic [NREGS-2:0]            wr_pulse_o,
   output logic                        fsm_state
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   localparam logic [AWIDTH-1:0] STATUS_ADDR = AWIDTH'(NREGS - 1);
   localparam logic [AWIDTH:0]   NREGS_W     = (AWIDTH + 1)'(NREGS);

   state_t              state;
   logic [AWIDTH-1:0]   addr_q;
   logic                write_q;
   logic [DWIDTH-1:0]   wdata_q;
   logic [DWIDTH-1:0]   regs [NREGS-1];
   logic [NREGS-2:0]    pulse;
   logic                ready;
   logic                err;

`ifdef APB_REGFILE_WAIT_EN
   logic [3:0]          cnt;
   assign ready = (state == ACCESS) && (cnt == 4'd0);
`else
   assign ready = (state == ACCESS);
`endif

   // Faults are decided purely from the transfer captured in the setup cycle.
   assign err = ({1'b0, addr_q} >= NREGS_W) || (write_q && (addr_q == STATUS_ADDR));

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state   <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         pulse   <= '0;
         for (int k = 0; k < NREGS - 1; k++) regs[k] <= DWIDTH'(RESET_VAL);
`ifdef APB_REGFILE_WAIT_EN
         cnt     <= '0;
`endif
      end else begin
         pulse <= '0;
         case (state)
            IDLE: begin
               if (PSEL && !PENABLE) begin
                  state   <= ACCESS;
                  addr_q  <= PADDR;
                  write_q <= PWRITE;
                  wdata_q <= PWDATA;
`ifdef APB_REGFILE_WAIT_EN
                  cnt     <= 4'(WAIT);
`endif
               end
            end
            ACCESS: begin
               if (!PSEL) begin
                  state <= IDLE;
               end else if (PENABLE) begin
                  if (ready) begin
                     state <= IDLE;
                     if (write_q && !err) begin
                        for (int k = 0; k < NREGS - 1; k++) begin
                           if (addr_q == AWIDTH'(k)) begin
                              regs[k]  <= wdata_q;
                              pulse[k] <= 1'b1;
                           end
                        end
                     end
                  end
`ifdef APB_REGFILE_WAIT_EN
                  else begin
                     cnt <= cnt - 4'd1;
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      PRDATA = '0;
      if (ready && !write_q && !err) begin
         if (addr_q == STATUS_ADDR) begin
            PRDATA = status_i;
         end else begin
            for (int k = 0; k < NREGS - 1; k++) begin
               if (addr_q == AWIDTH'(k)) PRDATA = regs[k];
            end
         end
      end
   end

   always_comb begin
      regs_o = '0;
      for (int k = 0; k < NREGS - 1; k++) regs_o[k*DWIDTH +: DWIDTH] = regs[k];
   end

   assign PREADY     = ready;
   assign PSLVERR    = ready && err;
   assign wr_pulse_o = pulse;
   assign fsm_state  = state;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: directed scenarios plus random transfers against an array model.
module tb_apb_regfile_slave;

   localparam int AWIDTH = 4;
   localparam int DWIDTH = 8;
   localparam int NREGS  = 8;
   localparam int WAIT   = 2;
`ifdef APB_REGFILE_WAIT_EN
   localparam int EFF_WAIT = WAIT;
`else
   localparam int EFF_WAIT = 0;
`endif
   localparam int RW_N = NREGS - 1;
   localparam int FW   = RW_N * DWIDTH;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              PSEL, PENABLE, PWRITE;
   logic [AWIDTH-1:0] PADDR;
   logic [DWIDTH-1:0] PWDATA;
   logic [DWIDTH-1:0] PRDATA;
   logic              PREADY, PSLVERR;
   logic [DWIDTH-1:0] status_i;
   logic [FW-1:0]     regs_o;
   logic [RW_N-1:0]   wr_pulse_o;
   logic              fsm_state;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   logic [DWIDTH-1:0] model_regs [RW_N];

   apb_regfile_slave #(
      .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .NREGS(NREGS), .WAIT(WAIT), .RESET_VAL(0)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .status_i(status_i), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .fsm_state(fsm_state)
   );

   // clock / cycle counter
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   // reference model
   function automatic logic [FW-1:0] model_flat();
      logic [FW-1:0] f = '0;
      for (int k = 0; k < RW_N; k++) f[k*DWIDTH +: DWIDTH] = model_regs[k];
      return f;
   endfunction

   function automatic logic model_err(input logic wr, input logic [AWIDTH-1:0] a);
      return (int'(a) >= NREGS) || (wr && int'(a) == NREGS - 1);
   endfunction

   function automatic logic [DWIDTH-1:0] model_read(input logic [AWIDTH-1:0] a);
      if (int'(a) >= NREGS) return '0;
      if (int'(a) == NREGS - 1) return status_i;
      return model_regs[a];
   endfunction

   // driver: starts at #1 after a rising edge, returns #1 after the completion edge
   task automatic apb_xfer(input logic wr, input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d,
                           output logic [DWIDTH-1:0] rd, output logic er, output int acc,
                           output int done_cyc, output logic [FW-1:0] regs_after,
                           output logic [RW_N-1:0] pulse_after);
      rd = '0; er = 1'b0; acc = -1; done_cyc = -1; regs_after = '0; pulse_after = '0;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      PWDATA  = ~d;
      for (int i = 1; i <= 40; i++) begin
         if (PREADY === 1'b1) begin
            rd = PRDATA; er = PSLVERR; acc = i; done_cyc = cyc;
            break;
         end
         @(posedge PCLK); #1;
      end
      if (acc < 0) begin
         vectors++; miscompares++;
         $display("FAIL timeout: PREADY never rose (addr %0d write %0b)", a, wr);
      end else begin
         @(posedge PCLK); #1;
         regs_after  = regs_o;
         pulse_after = wr_pulse_o;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic idle_cycle();
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
   endtask

   task automatic test_reset();
      logic [DWIDTH-1:0] rd; logic er; int acc, dc; logic [FW-1:0] ra; logic [RW_N-1:0] pa;
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      status_i = 8'h5A;
      repeat (3) @(posedge PCLK);
      #1;
      PRESET = 1'b0;
      for (int k = 0; k < RW_N; k++) model_regs[k] = '0;
      @(posedge PCLK); #1;
      vectors++;
      if ({PREADY, PSLVERR, PRDATA} !== '0) begin
         miscompares++; $display("FAIL reset_bus: got %b/%b/%h expected 0/0/00", PREADY, PSLVERR, PRDATA);
      end
      vectors++;
      if (regs_o !== '0 || wr_pulse_o !== '0 || fsm_state !== 1'b0) begin
         miscompares++; $display("FAIL reset_regs: got %h/%b/%b expected zeros", regs_o, wr_pulse_o, fsm_state);
      end
      apb_xfer(1'b0, 4'd0, 8'h00, rd, er, acc, dc, ra, pa);
      vectors++;
      if (rd !== 8'h00 || er !== 1'b0) begin
         miscompares++; $display("FAIL reset_read0: got %h err %b expected 00 err 0", rd, er);
      end
      vectors++;
      if (acc !== EFF_WAIT + 1) begin
         miscompares++; $display("FAIL reset_read0_lat: got %0d access cycles expected %0d", acc, EFF_WAIT + 1);
      end
   endtask

   task automatic test_write_wait();
      logic [DWIDTH-1:0] rd; logic er; int acc, dc; logic [FW-1:0] ra; logic [RW_N-1:0] pa;
      apb_xfer(1'b1, 4'd3, 8'hA5, rd, er, acc, dc, ra, pa);
      model_regs[3] = 8'hA5;
      vectors++;
      if (acc !== EFF_WAIT + 1 || er !== 1'b0) begin
         miscompares++; $display("FAIL write3_lat: got %0d cycles err %b expected %0d err 0", acc, er, EFF_WAIT + 1);
      end
      vectors++;
      if (ra !== model_flat()) begin
         miscompares++; $display("FAIL write3_regs: got %h expected %h", ra, model_flat());
      end
      vectors++;
      if (pa !== 7'b000_1000) begin
         miscompares++; $display("FAIL write3_pulse: got %b expected 0001000", pa);
      end
      idle_cycle();
      vectors++;
      if (wr_pulse_o !== '0) begin
         miscompares++; $display("FAIL write3_pulse_len: got %b expected 0", wr_pulse_o);
      end
      apb_xfer(1'b0, 4'd3, 8'h00, rd, er, acc, dc, ra, pa);
      vectors++;
      if (rd !== 8'hA5 || er !== 1'b0) begin
         miscompares++; $display("FAIL read3: got %h err %b expected a5 err 0", rd, er);
      end
   endtask

   task automatic test_status();
      logic [DWIDTH-1:0] rd; logic er; int acc, dc; logic [FW-1:0] ra; logic [RW_N-1:0] pa;
      status_i = 8'h3C;
      apb_xfer(1'b0, 4'd7, 8'h00, rd, er, acc, dc, ra, pa);
      vectors++;
      if (rd !== 8'h3C || er !== 1'b0) begin
         miscompares++; $display("FAIL status_read: got %h err %b expected 3c err 0", rd, er);
      end
      apb_xfer(1'b1, 4'd7, 8'hFF, rd, er, acc, dc, ra, pa);
      vectors++;
      if (er !== 1'b1 || pa !== '0 || ra !== model_flat()) begin
         miscompares++; $display("FAIL status_write: got err %b pulse %b regs %h expected 1/0/%h", er, pa, ra, model_flat());
      end
   endtask

   task automatic test_unmapped();
      logic [DWIDTH-1:0] rd; logic er; int acc, dc; logic [FW-1:0] ra; logic [RW_N-1:0] pa;
      apb_xfer(1'b0, 4'd9, 8'h00, rd, er, acc, dc, ra, pa);
      vectors++;
      if (rd !== 8'h00 || er !== 1'b1) begin
         miscompares++; $display("FAIL unmapped_read: got %h err %b expected 00 err 1", rd, er);
      end
      apb_xfer(1'b1, 4'd15, 8'hC3, rd, er, acc, dc, ra, pa);
      vectors++;
      if (er !== 1'b1 || pa !== '0 || ra !== model_flat()) begin
         miscompares++; $display("FAIL unmapped_write: got err %b pulse %b regs %h expected 1/0/%h", er, pa, ra, model_flat());
      end
   endtask

   task automatic test_back_to_back();
      logic [DWIDTH-1:0] rd; logic er; int acc, d1, d2; logic [FW-1:0] ra; logic [RW_N-1:0] pa;
      apb_xfer(1'b1, 4'd1, 8'h11, rd, er, acc, d1, ra, pa);
      model_regs[1] = 8'h11;
      apb_xfer(1'b0, 4'd1, 8'h00, rd, er, acc, d2, ra, pa);
      vectors++;
      if (rd !== 8'h11 || er !== 1'b0) begin
         miscompares++; $display("FAIL b2b_read: got %h err %b expected 11 err 0", rd, er);
      end
      vectors++;
      if (d2 - d1 !== 2 + EFF_WAIT) begin
         miscompares++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", d2 - d1, 2 + EFF_WAIT);
      end
   endtask

   task automatic test_ignored_penable();
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 4'd0; PWDATA = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         @(posedge PCLK); #1;
         vectors++;
         if (PREADY !== 1'b0 || fsm_state !== 1'b0) begin
            miscompares++; $display("FAIL stray_penable: got ready %b state %b expected 0/0", PREADY, fsm_state);
         end
      end
      idle_cycle();
      vectors++;
      if (regs_o !== model_flat() || wr_pulse_o !== '0) begin
         miscompares++; $display("FAIL stray_penable_regs: got %h/%b expected %h/0", regs_o, wr_pulse_o, model_flat());
      end
   endtask

   task automatic test_abort();
      logic [DWIDTH-1:0] rd; logic er; int acc, dc; logic [FW-1:0] ra; logic [RW_N-1:0] pa;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd2; PWDATA = 8'h77;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge PCLK); #1;
         vectors++;
         if (fsm_state !== 1'b0 || wr_pulse_o !== '0 || regs_o !== model_flat()) begin
            miscompares++; $display("FAIL abort: got state %b pulse %b regs %h expected 0/0/%h", fsm_state, wr_pulse_o, regs_o, model_flat());
         end
      end
      apb_xfer(1'b0, 4'd2, 8'h00, rd, er, acc, dc, ra, pa);
      vectors++;
      if (rd !== model_regs[2] || er !== 1'b0) begin
         miscompares++; $display("FAIL abort_read2: got %h err %b expected %h err 0", rd, er, model_regs[2]);
      end
   endtask

   task automatic test_reset_mid();
      logic [DWIDTH-1:0] rd; logic er; int acc, dc; logic [FW-1:0] ra; logic [RW_N-1:0] pa;
      for (int k = 0; k < RW_N; k++) begin
         apb_xfer(1'b1, AWIDTH'(k), 8'(k * 16 + 9), rd, er, acc, dc, ra, pa);
         model_regs[k] = 8'(k * 16 + 9);
      end
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd4; PWDATA = 8'h42;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      PRESET  = 1'b1;
      #1;
      for (int k = 0; k < RW_N; k++) model_regs[k] = '0;
      vectors++;
      if (fsm_state !== 1'b0 || regs_o !== '0 || PREADY !== 1'b0 || wr_pulse_o !== '0) begin
         miscompares++; $display("FAIL reset_mid: got state %b regs %h ready %b pulse %b expected zeros", fsm_state, regs_o, PREADY, wr_pulse_o);
      end
      @(posedge PCLK); #1;
      PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      vectors++;
      if (fsm_state !== 1'b0 || regs_o !== '0 || PREADY !== 1'b0) begin
         miscompares++; $display("FAIL reset_mid_after: got state %b regs %h ready %b expected zeros", fsm_state, regs_o, PREADY);
      end
   endtask

   task automatic test_random();
      logic [DWIDTH-1:0] rd, d, exp_rd; logic er, wr, exp_er; int acc, dc;
      logic [AWIDTH-1:0] a; logic [FW-1:0] ra; logic [RW_N-1:0] pa, exp_pa;
      for (int n = 0; n < 60; n++) begin
         wr = 1'($urandom_range(0, 1));
         a  = AWIDTH'($urandom_range(0, 15));
         d  = DWIDTH'($urandom_range(0, 255));
         status_i = DWIDTH'($urandom_range(0, 255));
         exp_er = model_err(wr, a);
         exp_rd = model_read(a);
         exp_pa = '0;
         if (wr && !exp_er) begin
            model_regs[a] = d;
            exp_pa[a] = 1'b1;
         end
         apb_xfer(wr, a, d, rd, er, acc, dc, ra, pa);
         vectors++;
         if (acc !== EFF_WAIT + 1 || er !== exp_er) begin
            miscompares++; $display("FAIL rand_%0d_resp: got %0d cycles err %b expected %0d err %b", n, acc, er, EFF_WAIT + 1, exp_er);
         end
         if (!wr) begin
            vectors++;
            if (rd !== exp_rd) begin
               miscompares++; $display("FAIL rand_%0d_rdata addr %0d: got %h expected %h", n, a, rd, exp_rd);
            end
         end
         vectors++;
         if (ra !== model_flat() || pa !== exp_pa) begin
            miscompares++; $display("FAIL rand_%0d_state: got %h/%b expected %h/%b", n, ra, pa, model_flat(), exp_pa);
         end
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_write_wait();
      test_status();
      test_unmapped();
      test_back_to_back();
      test_ignored_penable();
      test_abort();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
